// File: rtl/multiplier_arbiter_tainttrack.sv
// multiplier_arbiter_tainttrack: round-robin sharing of one sequential multiplier between two clients with taint tracking
module multiplier_arbiter_tainttrack #(
  parameter int WIDTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req0_t,
  input  logic                 req1,
  input  logic                 req1_t,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     a0_t,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     b0_t,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     a1_t,
  input  logic [WIDTH-1:0]     b1,
  input  logic [WIDTH-1:0]     b1_t,
  output logic                 ack0,
  output logic                 ack0_t,
  output logic                 ack1,
  output logic                 ack1_t,
  output logic                 resp_valid,
  output logic                 resp_valid_t,
  output logic                 resp_id,
  output logic                 resp_id_t,
  output logic [2*WIDTH-1:0]   resp_product,
  output logic [2*WIDTH-1:0]   resp_product_t,
  output logic                 mul_start,
  output logic                 mul_start_t,
  output logic [WIDTH-1:0]     mul_multiplier,
  output logic [WIDTH-1:0]     mul_multiplier_t,
  output logic [WIDTH-1:0]     mul_multiplicand,
  output logic [WIDTH-1:0]     mul_multiplicand_t,
  input  logic [2*WIDTH-1:0]   mul_product,
  input  logic [2*WIDTH-1:0]   mul_product_t,
  input  logic                 mul_done,
  input  logic                 mul_done_t
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t               state;
  logic                 last, last_t, owner, st_t, win;
  logic [WIDTH-1:0]     a_t_q, b_t_q;
  logic [2*WIDTH-1:0]   p_t_q;
  // round-robin pick: a lone requester wins, under contention the one not served last wins
  always_comb win = (req0 & req1) ? ~last : req1;
  assign ack0_t             = st_t;
  assign ack1_t             = st_t;
  assign mul_start_t        = st_t;
  assign resp_valid_t       = st_t;
  assign resp_id_t          = st_t;
  assign mul_multiplier_t   = a_t_q | {WIDTH{st_t}};
  assign mul_multiplicand_t = b_t_q | {WIDTH{st_t}};
  assign resp_product_t     = p_t_q | {(2*WIDTH){st_t}};
  // sequencer: grant, issue, wait for done, respond; strobes are single-cycle registered pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      last             <= 1'b1;
      last_t           <= 1'b0;
      owner            <= 1'b0;
      st_t             <= 1'b0;
      a_t_q            <= '0;
      b_t_q            <= '0;
      p_t_q            <= '0;
      ack0             <= 1'b0;
      ack1             <= 1'b0;
      mul_start        <= 1'b0;
      resp_valid       <= 1'b0;
      resp_id          <= 1'b0;
      resp_product     <= '0;
      mul_multiplier   <= '0;
      mul_multiplicand <= '0;
    end else begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      mul_start  <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req0 | req1) begin
          owner            <= win;
          mul_multiplier   <= win ? a1 : a0;
          mul_multiplicand <= win ? b1 : b0;
          a_t_q            <= win ? a1_t : a0_t;
          b_t_q            <= win ? b1_t : b0_t;
          st_t             <= st_t | req0_t | req1_t | last_t;
          ack0             <= ~win;
          ack1             <= win;
          mul_start        <= 1'b1;
          state            <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT: if (mul_done) begin
          resp_product <= mul_product;
          p_t_q        <= mul_product_t;
          st_t         <= st_t | mul_done_t;
          resp_valid   <= 1'b1;
          resp_id      <= owner;
          state        <= RESP;
        end
        RESP: begin
          last   <= owner;
          last_t <= st_t;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiplier_arbiter_tainttrack.sv
// tb_multiplier_arbiter_tainttrack: directed self-checking bench with a 9-cycle multiplier model
module tb_multiplier_arbiter_tainttrack;
  localparam int W = 8;
  logic clk = 0, rst = 1;
  logic req0 = 0, req0_t = 0, req1 = 0, req1_t = 0;
  logic [W-1:0] a0 = 0, a0_t = 0, b0 = 0, b0_t = 0, a1 = 0, a1_t = 0, b1 = 0, b1_t = 0;
  logic ack0, ack0_t, ack1, ack1_t, resp_valid, resp_valid_t, resp_id, resp_id_t;
  logic [2*W-1:0] resp_product, resp_product_t;
  logic mul_start, mul_start_t;
  logic [W-1:0] mul_multiplier, mul_multiplier_t, mul_multiplicand, mul_multiplicand_t;
  logic [2*W-1:0] mul_product, mul_product_t, pa, pt;
  logic mul_done, mul_done_t, done_t_inj = 0;
  logic [3:0] cnt;
  int n_cmp = 0, n_err = 0, who;

  multiplier_arbiter_tainttrack #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req0_t(req0_t), .req1(req1), .req1_t(req1_t),
    .a0(a0), .a0_t(a0_t), .b0(b0), .b0_t(b0_t),
    .a1(a1), .a1_t(a1_t), .b1(b1), .b1_t(b1_t),
    .ack0(ack0), .ack0_t(ack0_t), .ack1(ack1), .ack1_t(ack1_t),
    .resp_valid(resp_valid), .resp_valid_t(resp_valid_t),
    .resp_id(resp_id), .resp_id_t(resp_id_t),
    .resp_product(resp_product), .resp_product_t(resp_product_t),
    .mul_start(mul_start), .mul_start_t(mul_start_t),
    .mul_multiplier(mul_multiplier), .mul_multiplier_t(mul_multiplier_t),
    .mul_multiplicand(mul_multiplicand), .mul_multiplicand_t(mul_multiplicand_t),
    .mul_product(mul_product), .mul_product_t(mul_product_t),
    .mul_done(mul_done), .mul_done_t(mul_done_t)
  );

  always #5 clk = ~clk;

  // multiplier model: done pulses 9 cycles after start; product tainted wholesale if any operand bit is
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 0; mul_done <= 0; mul_done_t <= 0; mul_product <= 0; mul_product_t <= 0; pa <= 0; pt <= 0;
    end else if (mul_start) begin
      cnt <= 9; mul_done <= 0;
      pa <= 16'(mul_multiplier) * 16'(mul_multiplicand);
      pt <= |(mul_multiplier_t | mul_multiplicand_t) ? 16'hffff : 16'h0;
    end else if (cnt == 1) begin
      cnt <= 0; mul_done <= 1; mul_product <= pa; mul_product_t <= pt; mul_done_t <= done_t_inj;
    end else begin
      if (cnt != 0) cnt <= cnt - 1;
      mul_done <= 0; mul_done_t <= 0;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int w);
    int i;
    for (i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack0 | ack1) break;
    end
    chk("ack_seen", {15'b0, ack0 | ack1}, 16'd1);
    chk("ack_onehot", {15'b0, ack0 & ack1}, 16'd0);
    chk("start_with_ack", {15'b0, mul_start}, 16'd1);
    w = ack1;
  endtask

  task automatic wait_resp();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_valid) break;
      chk("no_ack_busy", {15'b0, ack0 | ack1}, 16'd0);
    end
    chk("resp_seen", {15'b0, resp_valid}, 16'd1);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ack0", {15'b0, ack0}, 0);
    chk("rst_start", {15'b0, mul_start}, 0);
    chk("rst_valid", {15'b0, resp_valid}, 0);
    chk("rst_prod", resp_product, 0);
    chk("rst_prod_t", resp_product_t, 0);
    chk("rst_mplier_t", {8'b0, mul_multiplier_t}, 0);
    rst = 0;
    // single request from client 0
    @(negedge clk);
    req0 = 1; a0 = 13; b0 = 11;
    wait_ack(who);
    chk("t1_who", who[15:0], 0);
    chk("t1_mplier", {8'b0, mul_multiplier}, 13);
    chk("t1_mcand", {8'b0, mul_multiplicand}, 11);
    chk("t1_ack_t", {15'b0, ack0_t}, 0);
    req0 = 0;
    @(negedge clk);
    chk("t1_ack_drop", {15'b0, ack0}, 0);
    chk("t1_start_drop", {15'b0, mul_start}, 0);
    wait_resp();
    chk("t1_id", {15'b0, resp_id}, 0);
    chk("t1_prod", resp_product, 143);
    chk("t1_prod_t", resp_product_t, 0);
    chk("t1_valid_t", {15'b0, resp_valid_t}, 0);
    @(negedge clk);
    chk("t1_valid_pulse", {15'b0, resp_valid}, 0);
    chk("t1_prod_hold", resp_product, 143);
    // contention from reset: 0, 1, 0
    rst = 1; @(negedge clk); rst = 0;
    req0 = 1; req1 = 1; a0 = 3; b0 = 5; a1 = 7; b1 = 9;
    wait_ack(who); chk("t2_first", who[15:0], 0);
    wait_resp(); chk("t2_id0", {15'b0, resp_id}, 0); chk("t2_p0", resp_product, 15);
    wait_ack(who); chk("t2_second", who[15:0], 1);
    wait_resp(); chk("t2_id1", {15'b0, resp_id}, 1); chk("t2_p1", resp_product, 63);
    wait_ack(who); chk("t2_third", who[15:0], 0);
    req0 = 0; req1 = 0;
    wait_resp(); chk("t2_id2", {15'b0, resp_id}, 0); chk("t2_p2", resp_product, 15);
    // late request from client 1 waits for the next idle cycle
    rst = 1; @(negedge clk); rst = 0;
    req0 = 1; a0 = 13; b0 = 11;
    wait_ack(who); chk("t3_who", who[15:0], 0);
    req0 = 0; req1 = 1; a1 = 12; b1 = 10;
    wait_resp(); chk("t3_id0", {15'b0, resp_id}, 0); chk("t3_p0", resp_product, 143);
    @(negedge clk); chk("t3_no_ack_idle", {15'b0, ack1}, 0);
    @(negedge clk); chk("t3_ack1", {15'b0, ack1}, 1);
    req1 = 0;
    wait_resp(); chk("t3_id1", {15'b0, resp_id}, 1); chk("t3_p1", resp_product, 120);
    // operand taint only
    @(negedge clk);
    req0 = 1; a0 = 13; b0 = 11; a0_t = 8'h01;
    wait_ack(who);
    chk("t4_mplier_t", {8'b0, mul_multiplier_t}, 16'h01);
    chk("t4_mcand_t", {8'b0, mul_multiplicand_t}, 0);
    chk("t4_ack_t", {15'b0, ack0_t}, 0);
    chk("t4_start_t", {15'b0, mul_start_t}, 0);
    req0 = 0; a0_t = 0;
    wait_resp();
    chk("t4_prod", resp_product, 143);
    chk("t4_prod_t", resp_product_t, 16'hffff);
    chk("t4_valid_t", {15'b0, resp_valid_t}, 0);
    chk("t4_id_t", {15'b0, resp_id_t}, 0);
    // tainted request makes st_t sticky
    @(negedge clk);
    req1 = 1; req1_t = 1; a1 = 2; b1 = 3;
    wait_ack(who);
    chk("t5_who", who[15:0], 1);
    chk("t5_ack_t", {15'b0, ack1_t}, 1);
    chk("t5_mplier_t", {8'b0, mul_multiplier_t}, 16'hff);
    req1 = 0; req1_t = 0;
    wait_resp();
    chk("t5_prod", resp_product, 6);
    chk("t5_prod_t", resp_product_t, 16'hffff);
    chk("t5_valid_t", {15'b0, resp_valid_t}, 1);
    chk("t5_id_t", {15'b0, resp_id_t}, 1);
    @(negedge clk);
    req0 = 1; a0 = 4; b0 = 5;
    wait_ack(who);
    chk("t5_sticky_ack_t", {15'b0, ack0_t}, 1);
    req0 = 0;
    wait_resp();
    chk("t5_prod2", resp_product, 20);
    chk("t5_sticky_valid_t", {15'b0, resp_valid_t}, 1);
    // reset in WAIT clears everything; contention afterwards goes to client 0
    @(negedge clk);
    req0 = 1; a0 = 13; b0 = 11;
    wait_ack(who);
    req0 = 0;
    repeat (3) @(negedge clk);
    rst = 1; #1;
    chk("t6_ack_t", {15'b0, ack0_t}, 0);
    chk("t6_start", {15'b0, mul_start}, 0);
    chk("t6_valid", {15'b0, resp_valid}, 0);
    chk("t6_prod", resp_product, 0);
    chk("t6_prod_t", resp_product_t, 0);
    chk("t6_mplier", {8'b0, mul_multiplier}, 0);
    @(negedge clk); rst = 0;
    req0 = 1; req1 = 1; a0 = 3; b0 = 5; a1 = 7; b1 = 9;
    wait_ack(who);
    chk("t6_first", who[15:0], 0);
    chk("t6_ack_t_clean", {15'b0, ack0_t}, 0);
    req0 = 0; req1 = 0;
    wait_resp(); chk("t6_p", resp_product, 15);
    // done taint at WAIT exit
    done_t_inj = 1;
    @(negedge clk);
    req0 = 1; a0 = 13; b0 = 11;
    wait_ack(who);
    chk("t7_ack_t", {15'b0, ack0_t}, 0);
    req0 = 0;
    wait_resp();
    done_t_inj = 0;
    chk("t7_valid_t", {15'b0, resp_valid_t}, 1);
    chk("t7_id_t", {15'b0, resp_id_t}, 1);
    chk("t7_prod_t", resp_product_t, 16'hffff);
    @(negedge clk);
    req1 = 1; a1 = 12; b1 = 10;
    wait_ack(who);
    chk("t7_sticky_ack1_t", {15'b0, ack1_t}, 1);
    req1 = 0;
    wait_resp();
    chk("t7_p", resp_product, 120);
    chk("t7_sticky_prod_t", resp_product_t, 16'hffff);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multiplier_arbiter_tainttrack.md
# multiplier_arbiter_tainttrack

Round-robin arbiter and sequencer that shares one taint-tracked sequential multiplier between two requesters. It sits between two client ports and the multiplier's start/operand/product/done interface. It latches the winning request's operands, pulses start, waits for done, and returns the product tagged with the requester id. A shadow `_t` taint bit accompanies every data and control signal; taint propagates conservatively through every arbitration and timing decision.

## Interface
- WIDTH, 1024, operand width; product is 2*WIDTH.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0, req0_t / req1, req1_t  in  1  request from client 0/1; held high with operands stable until ack.
- a0, a0_t, b0, b0_t / a1, a1_t, b1, b1_t  in  WIDTH  multiplier/multiplicand operands and taints for client 0/1.
- ack0, ack0_t / ack1, ack1_t  out  1  one-cycle acceptance pulse to client 0/1.
- resp_valid, resp_valid_t  out  1  one-cycle result strobe.
- resp_id, resp_id_t  out  1  client that owns resp_product.
- resp_product, resp_product_t  out  2*WIDTH  result and taint; held until next RESP.
- mul_start, mul_start_t  out  1  start pulse to the multiplier.
- mul_multiplier, mul_multiplier_t, mul_multiplicand, mul_multiplicand_t  out  WIDTH  latched operands to the multiplier.
- mul_product, mul_product_t  in  2*WIDTH  multiplier product.
- mul_done, mul_done_t  in  1  multiplier productDone.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: when req0|req1, pick a winner, latch its a/b and a_t/b_t, record owner, go to ISSUE. No request: stay.
- Arbitration: only one requests, it wins. Both request, the one != last wins. last resets to 1, so client 0 wins the first contest.
- ISSUE (1 cycle): mul_start=1, ack[owner]=1 → WAIT.
- WAIT: mul_done sampled; on 1 → latch mul_product/mul_product_t, go to RESP. mul_done during ISSUE is ignored.
- RESP (1 cycle): resp_valid=1, resp_id=owner; last<=owner → IDLE.
- Requests arriving in ISSUE/WAIT/RESP are not acked. They are arbitrated in the next IDLE cycle.
- Taint register st_t is sticky and cleared only by rst. At a grant edge, st_t <= st_t|req0_t|req1_t|last_t. At a WAIT exit edge, st_t <= st_t|mul_done_t. last_t <= st_t-next on RESP.
- Taint outputs:
  - mul_start_t, ack*_t, resp_valid_t and resp_id_t all equal st_t.
  - Operand taints: latched taint | {WIDTH{st_t}}.
  - resp_product_t: latched mul_product_t | {2W{st_t}}.
- Data path: no arithmetic is done here. Operand and product values pass through unmodified.

## Timing
- Reset (async) values:
  - State IDLE, last=1, all taint registers 0, owner 0.
  - All outputs 0: ack*, mul_start, resp_valid, resp_id, operand and product registers, and every `_t`.
- Request seen at edge k: ISSUE (ack, mul_start) during cycle k+1, WAIT from k+2.
- mul_done seen at edge m: resp_valid during cycle m+1. Back in IDLE at m+2, so a new grant is earliest at edge m+2.
- Overhead is 3 cycles plus multiplier latency. Back-to-back requests are served alternately under contention.
- ack and mul_start are registered and coincide exactly.
- rst mid-operation: immediate return to IDLE with all outputs 0. The pending client must re-request; the multiplier is reset by the same rst.

## Test plan
- WIDTH=8, single req0 a0=13 b0=11, model multiplier done 9 cycles after start → ack0 and mul_start in the same cycle; resp_valid one cycle, resp_id=0, resp_product=143; all `_t`=0.
- req0 and req1 held high together from reset, a0=3 b0=5, a1=7 b1=9 → served in order 0 (15), 1 (63), 0 (15); no ack while busy.
- req1 asserted during WAIT of a client-0 op → no ack1 until IDLE; ack1 is the cycle after resp_valid(id0)+1; result correct.
- a0_t=8'h01 only, untainted control → mul_multiplier_t=8'h01; resp_product_t equals the model's product_t; st_t stays 0.
- req1_t=1 on grant, or mul_done_t=1 at WAIT exit → st_t=1 from then on; every later ack/resp_valid/resp_id taint=1; product taint all-ones; persists until rst.
- rst asserted in WAIT → same-cycle outputs 0, state IDLE; the following req0 is served as the first op (client 0 wins a contest).
